// File: rtl/axon_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : axon_scheduler_if
// Brief    : Router-local-port / neuron-core bundle for the axon scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface axon_scheduler_if #(
    parameter int NUM_AXONS = 256
);
    logic [13:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 tick;
    logic [NUM_AXONS-1:0] axon_vec;
    logic                 axon_vec_valid;
    logic                 axon_vec_ready;
    logic [3:0]           cur_slot;
    logic [7:0]           dup_cnt;
    logic                 overrun_err;

    modport master (
        output in_data, in_valid, tick, axon_vec_ready,
        input  in_ready, axon_vec, axon_vec_valid, cur_slot, dup_cnt, overrun_err
    );

    modport slave (
        input  in_data, in_valid, tick, axon_vec_ready,
        output in_ready, axon_vec, axon_vec_valid, cur_slot, dup_cnt, overrun_err
    );
endinterface
`default_nettype wire

// File: rtl/axon_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : axon_scheduler
// Brief    : 16-slot spike delivery bitmap, read out one slot per global tick.
// Revision : 1.0 - initial release
// ============================================================================
module axon_scheduler #(
    parameter int NUM_AXONS = 256
) (
    input  logic             clk,
    input  logic             rst,
    axon_scheduler_if.slave  bus
);
    localparam int                   NUM_SLOTS    = 16;
    localparam logic [8:0]           c_AXON_LIMIT = 9'(NUM_AXONS);
    localparam logic [NUM_AXONS-1:0] c_ONE        = {{(NUM_AXONS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_AXONS-1:0] r_rows [NUM_SLOTS];
    logic [3:0]           r_cur_slot;
    logic [NUM_AXONS-1:0] r_axon_vec;
    logic [7:0]           r_dup_cnt;
    logic                 r_overrun;
    logic                 r_in_ready;

    logic [7:0]           w_axon;
    logic [3:0]           w_pkt_slot;
    logic                 w_write;
    logic [NUM_AXONS-1:0] w_bit;
    logic                 w_bypass;
    logic                 w_dup;

    assign w_axon     = bus.in_data[13:6];
    assign w_pkt_slot = bus.in_data[5:2];
    // Out-of-range axons are still handshaken, they just never reach the bitmap.
    assign w_write    = bus.in_valid && r_in_ready && ({1'b0, w_axon} < c_AXON_LIMIT);
    assign w_bit      = w_write ? (c_ONE << w_axon) : '0;
    assign w_bypass   = bus.tick && w_write && (w_pkt_slot == r_cur_slot);
    assign w_dup      = |(r_rows[w_pkt_slot] & w_bit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.tick) w_state_nxt = ST_HOLD;
            ST_HOLD: if (!bus.tick && bus.axon_vec_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // The tick clear is written last so it wins over a same-slot packet write;
    // a bypassed packet is delivered through axon_vec instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SLOTS; s++) r_rows[s] <= '0;
        end else begin
            if (w_write)  r_rows[w_pkt_slot] <= r_rows[w_pkt_slot] | w_bit;
            if (bus.tick) r_rows[r_cur_slot] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur_slot <= '0;
            r_axon_vec <= '0;
            r_dup_cnt  <= '0;
            r_overrun  <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= 1'b1;
            if (bus.tick) begin
                r_axon_vec <= r_rows[r_cur_slot] | (w_bypass ? w_bit : '0);
                r_cur_slot <= r_cur_slot + 4'd1;
                if (r_state == ST_HOLD && !bus.axon_vec_ready) r_overrun <= 1'b1;
            end
            if (w_dup && r_dup_cnt != 8'hFF) r_dup_cnt <= r_dup_cnt + 8'd1;
        end
    end

    assign bus.in_ready       = r_in_ready;
    assign bus.axon_vec       = r_axon_vec;
    assign bus.axon_vec_valid = (r_state == ST_HOLD);
    assign bus.cur_slot       = r_cur_slot;
    assign bus.dup_cnt        = r_dup_cnt;
    assign bus.overrun_err    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_axon_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_axon_scheduler
// Brief    : Self-checking bench: vector table plus scoreboard of tick readouts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axon_scheduler;
    localparam int NA = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axon_scheduler_if #(.NUM_AXONS(NA)) bus();
    axon_scheduler #(.NUM_AXONS(NA)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0;
    int n_errors = 0;

    logic [NA-1:0] m_rows [16];
    logic [3:0]    m_slot;
    int            m_dup;
    logic [NA-1:0] exp_q [$];

    typedef struct {
        bit         pv;
        logic [7:0] ax;
        logic [3:0] sl;
        bit         tk;
        bit         rdy;
        bit         e_valid;
        logic [3:0] e_slot;
        logic [7:0] e_dup;
    } vec_t;
    vec_t tbl [15];

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [NA-1:0] act, input logic [NA-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [NA-1:0] onehot(input logic [7:0] a);
        logic [NA-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_rows[i] = '0;
        m_slot = '0;
        m_dup  = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus; the expected readout is queued when a tick is driven
    // and popped once the DUT has presented it.
    task automatic step(input bit pv, input logic [7:0] ax, input logic [3:0] sl,
                        input bit tk, input bit rdy);
        logic [NA-1:0] pb;
        @(negedge clk);
        bus.in_valid       = pv;
        bus.in_data        = {ax, sl, 2'b11};
        bus.tick           = tk;
        bus.axon_vec_ready = rdy;
        pb = pv ? onehot(ax) : '0;
        if ((m_rows[sl] & pb) != '0 && m_dup < 255) m_dup++;
        if (tk) begin
            exp_q.push_back(m_rows[m_slot] | ((sl == m_slot) ? pb : '0));
            if (sl != m_slot) m_rows[sl] = m_rows[sl] | pb;
            m_rows[m_slot] = '0;
            m_slot = m_slot + 4'd1;
        end else begin
            m_rows[sl] = m_rows[sl] | pb;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.tick     = 1'b0;
        if (tk) begin
            chk_i("vec_valid_after_tick", int'(bus.axon_vec_valid), 1);
            chk_i("cur_slot_after_tick", int'(bus.cur_slot), int'(m_slot));
            if (exp_q.size() == 0) chk_i("scoreboard_empty", 0, 1);
            else chk_v("axon_vec", bus.axon_vec, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b0;
        bus.in_valid       = 1'b0;
        bus.tick           = 1'b0;
        bus.axon_vec_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_v("rst_axon_vec", bus.axon_vec, '0);
        chk_i("rst_valid", int'(bus.axon_vec_valid), 0);
        chk_i("rst_cur_slot", int'(bus.cur_slot), 0);
        chk_i("rst_dup_cnt", int'(bus.dup_cnt), 0);
        chk_i("rst_overrun", int'(bus.overrun_err), 0);
        chk_i("rst_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_i("in_ready_after_rst", int'(bus.in_ready), 1);
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst                = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_data        = '0;
        bus.tick           = 1'b0;
        bus.axon_vec_ready = 1'b1;
        model_reset();

        //            pv  ax     sl    tk rdy  valid slot  dup
        tbl[0]  = '{1, 8'h42, 4'd1, 0, 1, 0, 4'd0, 8'd0};
        tbl[1]  = '{0, 8'h00, 4'd0, 1, 1, 1, 4'd1, 8'd0};
        tbl[2]  = '{0, 8'h00, 4'd0, 0, 1, 0, 4'd1, 8'd0};
        tbl[3]  = '{0, 8'h00, 4'd0, 1, 0, 1, 4'd2, 8'd0};
        tbl[4]  = '{0, 8'h00, 4'd0, 0, 0, 1, 4'd2, 8'd0};
        tbl[5]  = '{0, 8'h00, 4'd0, 0, 1, 0, 4'd2, 8'd0};
        tbl[6]  = '{1, 8'h05, 4'd3, 0, 1, 0, 4'd2, 8'd0};
        tbl[7]  = '{1, 8'h05, 4'd3, 0, 1, 0, 4'd2, 8'd1};
        tbl[8]  = '{1, 8'h05, 4'd3, 0, 1, 0, 4'd2, 8'd2};
        tbl[9]  = '{0, 8'h00, 4'd0, 1, 1, 1, 4'd3, 8'd2};
        tbl[10] = '{0, 8'h00, 4'd0, 1, 1, 1, 4'd4, 8'd2};
        tbl[11] = '{1, 8'h07, 4'd5, 1, 1, 1, 4'd5, 8'd2};
        tbl[12] = '{1, 8'h10, 4'd5, 1, 1, 1, 4'd6, 8'd2};
        tbl[13] = '{0, 8'h00, 4'd0, 1, 1, 1, 4'd7, 8'd2};
        tbl[14] = '{1, 8'h20, 4'd4, 0, 1, 0, 4'd7, 8'd2};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].pv, tbl[i].ax, tbl[i].sl, tbl[i].tk, tbl[i].rdy);
            chk_i($sformatf("tbl%0d_valid", i), int'(bus.axon_vec_valid), int'(tbl[i].e_valid));
            chk_i($sformatf("tbl%0d_slot", i), int'(bus.cur_slot), int'(tbl[i].e_slot));
            chk_i($sformatf("tbl%0d_dup", i), int'(bus.dup_cnt), int'(tbl[i].e_dup));
        end
        chk_v("basic_bit66_model", onehot(8'h42), {{(NA-67){1'b0}}, 1'b1, 66'd0});

        // Same-cycle bypass at slot 0, then slot 0 must read empty a full lap later.
        do_reset();
        step(1, 8'h10, 4'd0, 1, 1);
        chk_v("bypass_bit16", bus.axon_vec, onehot(8'd16));
        for (int i = 0; i < 16; i++) step(0, 8'h00, 4'd0, 1, 1);
        chk_v("bypass_slot0_cleared", bus.axon_vec, '0);

        // Wrap-around: slot sequence 0..15,0,1; late packet lands on readout 17.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            chk_i($sformatf("wrap_slot_before_tick%0d", i), int'(bus.cur_slot), i % 16);
            if (i == 16) step(1, 8'h33, 4'd0, 0, 1);
            step(0, 8'h00, 4'd0, 1, 1);
        end
        chk_v("wrap_tick17_vec", bus.axon_vec, onehot(8'h33));
        chk_i("wrap_final_slot", int'(bus.cur_slot), 1);

        // Duplicate counter saturation.
        do_reset();
        for (int i = 0; i < 301; i++) step(1, 8'h05, 4'd3, 0, 1);
        chk_i("dup_saturated", int'(bus.dup_cnt), 255);

        // Overrun: two ticks with no consumer, then drain.
        do_reset();
        step(1, 8'h01, 4'd1, 0, 0);
        step(0, 8'h00, 4'd0, 1, 0);
        chk_i("overrun_after_first_tick", int'(bus.overrun_err), 0);
        step(0, 8'h00, 4'd0, 1, 0);
        chk_i("overrun_set", int'(bus.overrun_err), 1);
        chk_v("overrun_holds_second_row", bus.axon_vec, onehot(8'h01));
        step(0, 8'h00, 4'd0, 0, 1);
        chk_i("overrun_valid_drops", int'(bus.axon_vec_valid), 0);
        step(0, 8'h00, 4'd0, 0, 1);
        chk_i("overrun_sticky", int'(bus.overrun_err), 1);

        // Reset mid-hold with spikes pending in several slots.
        step(1, 8'h44, 4'd2, 0, 0);
        step(1, 8'h45, 4'd5, 0, 0);
        step(1, 8'h46, 4'd9, 0, 0);
        step(0, 8'h00, 4'd0, 1, 0);
        chk_v("midhold_vec_before_rst", bus.axon_vec, onehot(8'h44));
        do_reset();
        for (int i = 0; i < 16; i++) step(0, 8'h00, 4'd0, 1, 1);
        chk_v("midhold_last_vec_zero", bus.axon_vec, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
